// File: rtl/semafor_pkg.sv
// Shared definitions for every direction of the intersection: FSM states,
// the night-mode code and lamp encodings {rosu, galben, verde}.
package semafor_pkg;

  typedef enum logic [2:0] {
    INACTIV,
    ROSU_PRE,
    GALBEN_PRE,
    VERDE,
    GALBEN_POST,
    GATA,
    ASTEPT,
    NOAPTE
  } stare_t;

  localparam logic [2:0] STARE_NOAPTE = 3'b111;

  localparam logic [2:0] LAMPA_ROSU   = 3'b100;
  localparam logic [2:0] LAMPA_GALBEN = 3'b010;
  localparam logic [2:0] LAMPA_VERDE  = 3'b001;
  localparam logic [2:0] LAMPA_STINS  = 3'b000;

  // Lamp pattern shown while in state s; night mode blinks yellow with clipire.
  function automatic logic [2:0] lampi(input stare_t s, input logic clipire);
    logic [2:0] l;
    case (s)
      GALBEN_PRE, GALBEN_POST: l = LAMPA_GALBEN;
      VERDE:                   l = LAMPA_VERDE;
      NOAPTE:                  l = clipire ? LAMPA_GALBEN : LAMPA_STINS;
      default:                 l = LAMPA_ROSU;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/contor_faza.sv
// Phase duration counter: counts tick enables, clears on phase entry and
// saturates at all-ones so long phases never wrap.
module contor_faza #(
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/semafor_directie.sv
// Traffic light controller for one direction: sequences red/yellow/green
// when the central controller grants ID_STARE, with night blink override.
module semafor_directie
  import semafor_pkg::*;
#(
  parameter logic [2:0]  ID_STARE      = 3'b010,
  parameter int unsigned T_ROSU        = 1,
  parameter int unsigned T_GALBEN      = 2,
  parameter int unsigned T_VERDE_MIN   = 5,
  parameter int unsigned T_VERDE_MAX   = 15,
  parameter int unsigned T_GALBEN_POST = 2,
  parameter int unsigned CW            = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] stare_semafor,
  input  logic       tick,
  input  logic       clipire,
  input  logic       senzor,
  output logic       ready,
  output logic       rosu,
  output logic       galben,
  output logic       verde
);

  localparam logic [CW-1:0] C_ROSU   = CW'(T_ROSU);
  localparam logic [CW-1:0] C_GALBEN = CW'(T_GALBEN);
  localparam logic [CW-1:0] C_VMIN   = CW'(T_VERDE_MIN);
  localparam logic [CW-1:0] C_VMAX   = CW'(T_VERDE_MAX);
  localparam logic [CW-1:0] C_GPOST  = CW'(T_GALBEN_POST);
  // With no red hold the grant enters yellow directly.
  localparam stare_t INTRARE = (T_ROSU == 0) ? GALBEN_PRE : ROSU_PRE;

  stare_t        stare_q, stare_d;
  logic [2:0]    lampi_q;
  logic          ready_q;
  logic [CW-1:0] cnt;
  logic          clr;

  contor_faza #(.CW(CW)) u_contor (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .en_i  (tick),
    .cnt_o (cnt)
  );

  always_comb begin
    stare_d = stare_q;
    case (stare_q)
      INACTIV:     if (stare_semafor == ID_STARE) stare_d = INTRARE;
      ROSU_PRE:    if (cnt == C_ROSU) stare_d = GALBEN_PRE;
      GALBEN_PRE:  if (cnt == C_GALBEN) stare_d = VERDE;
      VERDE:       if (((cnt >= C_VMIN) && !senzor) || (cnt == C_VMAX)) stare_d = GALBEN_POST;
      GALBEN_POST: if (cnt == C_GPOST) stare_d = GATA;
      GATA:        stare_d = ASTEPT;
      ASTEPT:      if (stare_semafor != ID_STARE) stare_d = INACTIV;
      NOAPTE:      if (stare_semafor != STARE_NOAPTE)
                     stare_d = (stare_semafor == ID_STARE) ? INTRARE : INACTIV;
      default:     stare_d = INACTIV;
    endcase
    // Night mode and loss of grant override the normal sequence.
    if (stare_semafor == STARE_NOAPTE) begin
      stare_d = NOAPTE;
    end else if ((stare_q != NOAPTE) && (stare_semafor != ID_STARE)) begin
      stare_d = INACTIV;
    end
  end

  assign clr = (stare_d != stare_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stare_q <= INACTIV;
      lampi_q <= LAMPA_ROSU;
      ready_q <= 1'b0;
    end else begin
      stare_q <= stare_d;
      lampi_q <= lampi(stare_d, clipire);
      ready_q <= (stare_d == GATA);
    end
  end

  assign rosu   = lampi_q[2];
  assign galben = lampi_q[1];
  assign verde  = lampi_q[0];
  assign ready  = ready_q;

endmodule

// File: tb/tb_semafor_directie.sv
// Scoreboard bench: expected lamp runs (pattern, tick count, clk length) are
// queued with each stimulus and compared as the DUT output pattern changes.
module tb_semafor_directie;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] stare_semafor = 3'b000;
  logic       tick = 1'b0;
  logic       clipire = 1'b0;
  logic       senzor = 1'b0;
  logic       ready, rosu, galben, verde;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [3:0]  vec;
    int unsigned ticks;
    int unsigned clks;
  } run_t;

  run_t        exp_q[$];
  logic [3:0]  cur_vec = 4'b1000;
  int unsigned run_clks = 0, run_ticks = 0;
  bit          sb_en = 1'b0;
  int unsigned ready_cnt = 0, exp_ready = 0;
  logic [1:0]  tdiv = '0;

  semafor_directie dut (
    .clk           (clk),
    .rst           (rst),
    .stare_semafor (stare_semafor),
    .tick          (tick),
    .clipire       (clipire),
    .senzor        (senzor),
    .ready         (ready),
    .rosu          (rosu),
    .galben        (galben),
    .verde         (verde)
  );

  always #5 clk = ~clk;

  // Tick once every 4 clocks.
  always @(posedge clk) begin
    #1;
    tdiv = tdiv + 2'd1;
    tick = (tdiv == 2'd0);
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: {rosu,galben,verde,ready} runs, measured in clks and ticks.
  always @(negedge clk) begin
    logic [3:0] vec;
    run_t       e;
    vec = {rosu, galben, verde, ready};
    if (ready === 1'b1) ready_cnt++;
    if (vec !== cur_vec) begin
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_run", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("run_vec", cur_vec, e.vec);
          check("run_ticks", run_ticks, e.ticks);
          check("run_clks", run_clks, e.clks);
        end
      end
      cur_vec = vec;
      run_clks = 0;
      run_ticks = 0;
    end
    run_clks++;
    if (tick) run_ticks++;
  end

  task automatic push(input logic [3:0] v, input int unsigned t, input int unsigned c);
    run_t r;
    r.vec = v; r.ticks = t; r.clks = c;
    exp_q.push_back(r);
  endtask

  task automatic push_cycle(input int unsigned rosu_clks, input int unsigned verde_ticks);
    push(4'b1000, 1, rosu_clks);
    push(4'b0100, 2, 8);
    push(4'b0010, verde_ticks, 4 * verde_ticks);
    push(4'b0100, 2, 8);
    push(4'b1001, 0, 1);
  endtask

  // Grant the direction in the clock right after a tick.
  task automatic start_cycle();
    int unsigned n;
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (!tick && n < 16);
    @(posedge clk); #2;
    run_clks = 0;
    run_ticks = 0;
    sb_en = 1'b1;
    stare_semafor = 3'b010;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk); n++;
    end
    #1;
    check("sb_drain", exp_q.size(), 0);
  endtask

  task automatic wait_verde_ticks(input int unsigned want);
    int unsigned c, k;
    c = 0; k = 0;
    while (c < want && k < 300) begin
      @(posedge clk); #2;
      if (verde && tick) c++;
      k++;
    end
    check("verde_ticks_seen", c, want);
  endtask

  task automatic leave();
    @(posedge clk); #2;
    stare_semafor = 3'b000;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int unsigned n;
    logic        clip_prev;

    repeat (3) @(negedge clk);
    check("rst_rosu", rosu, 1);
    check("rst_gyr", {galben, verde, ready}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("inactiv_rosu", {rosu, galben, verde, ready}, 4'b1000);

    // Nominal cycle, then grant held with no restart.
    push_cycle(5, 5);
    start_cycle();
    drain();
    exp_ready++;
    check("astept_vec", {rosu, galben, verde, ready}, 4'b1000);
    repeat (200) @(negedge clk);
    check("hold_vec", {rosu, galben, verde, ready}, 4'b1000);
    check("hold_ready", ready_cnt, exp_ready);
    leave();

    // Vehicle present for the whole green: maximum green.
    senzor = 1'b1;
    push_cycle(5, 15);
    start_cycle();
    drain();
    exp_ready++;
    senzor = 1'b0;
    leave();

    // Vehicle leaves after the 8th green tick.
    senzor = 1'b1;
    push_cycle(5, 8);
    start_cycle();
    wait_verde_ticks(8);
    @(posedge clk); #2;
    senzor = 1'b0;
    drain();
    exp_ready++;
    leave();

    // Grant withdrawn in green.
    push(4'b1000, 1, 5);
    push(4'b0100, 2, 8);
    push(4'b0010, 2, 8);
    start_cycle();
    wait_verde_ticks(2);
    @(posedge clk); #2;
    stare_semafor = 3'b001;
    @(negedge clk);
    @(negedge clk);
    check("abort_rosu", rosu, 1);
    check("abort_verde", verde, 0);
    drain();
    repeat (20) @(negedge clk);
    check("abort_ready", ready_cnt, exp_ready);

    // Night blink, then re-grant straight from night mode.
    sb_en = 1'b0;
    @(posedge clk); #2;
    stare_semafor = 3'b111;
    clipire = 1'b0;
    repeat (2) @(posedge clk);
    clip_prev = clipire;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      clipire = (((i / 8) % 2) == 1);
      @(negedge clk);
      check("noapte_galben", galben, clip_prev);
      check("noapte_rvr", {rosu, verde, ready}, 0);
      clip_prev = clipire;
    end
    repeat (2) @(posedge clk);
    push(4'b0000, 0, 1);
    push(4'b1000, 1, 4);
    push(4'b0100, 2, 8);
    push(4'b0010, 5, 20);
    push(4'b0100, 2, 8);
    push(4'b1001, 0, 1);
    start_cycle();
    drain();
    exp_ready++;
    leave();

    // Asynchronous reset between edges during pre-green yellow.
    push(4'b1000, 1, 5);
    start_cycle();
    n = 0;
    while (galben !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    #1;
    sb_en = 1'b0;
    check("pre_galben", galben, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_rosu", rosu, 1);
    check("arst_galben", galben, 0);
    check("arst_vr", {verde, ready}, 0);
    stare_semafor = 3'b000;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_vec", {rosu, galben, verde, ready}, 4'b1000);
    check("post_rst_ready", ready_cnt, exp_ready);

    // Normal operation after reset.
    push_cycle(5, 5);
    start_cycle();
    drain();
    exp_ready++;
    repeat (10) @(negedge clk);
    check("total_ready", ready_cnt, exp_ready);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
